// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, streams words from instruction memory into a
// small prefetch FIFO for the core. Define IFETCH_ALIGN_CHK_EN to fault and halt on misaligned redirects.
module instr_fetch_ctrl #(
  parameter int unsigned            BUS_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0,
  parameter int unsigned            BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  next_instr,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [BUS_WIDTH-1:0]  instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [BUS_WIDTH-1:0]  mem_rdata,
  output logic                  fetch_fault
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
  localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(4);

`ifdef IFETCH_ALIGN_CHK_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2,
    ST_HALT  = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } state_e;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));
`endif

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0]   drop_addr_q, drop_addr_d;
  logic [BUS_WIDTH-1:0]    data_q [BUF_DEPTH];
  logic [BUS_WIDTH-1:0]    data_d [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]   pcbuf_q [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]   pcbuf_d [BUF_DEPTH];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
`ifdef IFETCH_ALIGN_CHK_EN
  logic                    fault_q, fault_d;
  logic                    halt_pend_q, halt_pend_d;
  logic                    misaligned_s;
`endif

  logic                    req_s;
  logic                    pending_s;
  logic                    push_s;
  logic                    pop_s;
  logic [ADDR_WIDTH-1:0]   target_pc_s;

`ifdef IFETCH_ALIGN_CHK_EN
  assign misaligned_s = (redirect_pc[1:0] != 2'b00);
  assign target_pc_s  = redirect_pc;
  assign fetch_fault  = fault_q;
`else
  assign target_pc_s  = redirect_pc & ALIGN_MASK;
  assign fetch_fault  = 1'b0;
`endif

  // The request is a function of registered state only, so a same-cycle pop cannot re-open it.
  assign req_s     = ((state_q == ST_FETCH) && (count_q < CNT_FULL)) || (state_q == ST_DROP);
  assign pending_s = req_s && !mem_ack;
  assign push_s    = req_s && mem_ack && (state_q == ST_FETCH) && !redirect_valid;
  assign pop_s     = (count_q != CNT_ZERO) && next_instr && !redirect_valid;

  assign mem_req     = req_s;
  assign mem_addr    = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;
  assign instr_valid = (count_q != CNT_ZERO);
  assign instruction = instr_valid ? data_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? pcbuf_q[rd_ptr_q] : '0;

  // Fetch sequencing: next state, fetch PC, held drop address and fault tracking.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
`ifdef IFETCH_ALIGN_CHK_EN
    fault_d     = fault_q;
    halt_pend_d = halt_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (redirect_valid) begin
          fetch_pc_d = target_pc_s;
`ifdef IFETCH_ALIGN_CHK_EN
          if (misaligned_s) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end else begin
            fault_d = 1'b0;
          end
`endif
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
      end
      ST_FETCH: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc_s;
          // An unacknowledged request must still be completed; its data is thrown away in DROP.
          if (pending_s) begin
            state_d     = ST_DROP;
            drop_addr_d = fetch_pc_q;
          end else begin
            state_d = ST_FETCH;
          end
`ifdef IFETCH_ALIGN_CHK_EN
          if (misaligned_s) begin
            fault_d = 1'b1;
            if (pending_s) begin
              halt_pend_d = 1'b1;
            end else begin
              state_d = ST_HALT;
            end
          end else begin
            halt_pend_d = 1'b0;
          end
`endif
        end else if (push_s) begin
          fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
      end
      ST_DROP: begin
        if (redirect_valid) begin
          fetch_pc_d = target_pc_s;
`ifdef IFETCH_ALIGN_CHK_EN
          fault_d     = misaligned_s;
          halt_pend_d = misaligned_s;
`endif
        end else begin
          fetch_pc_d = fetch_pc_q;
        end
        if (mem_ack) begin
`ifdef IFETCH_ALIGN_CHK_EN
          state_d     = halt_pend_d ? ST_HALT : ST_FETCH;
          halt_pend_d = 1'b0;
`else
          state_d = ST_FETCH;
`endif
        end else begin
          state_d = ST_DROP;
        end
      end
`ifdef IFETCH_ALIGN_CHK_EN
      ST_HALT: begin
        if (redirect_valid && !misaligned_s) begin
          fault_d    = 1'b0;
          fetch_pc_d = target_pc_s;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_HALT;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Prefetch FIFO bookkeeping; a redirect empties it regardless of a same-cycle pop or push.
  always_comb begin
    data_d   = data_q;
    pcbuf_d  = pcbuf_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = CNT_ZERO;
    end else begin
      if (push_s) begin
        data_d[wr_ptr_q]  = mem_rdata;
        pcbuf_d[wr_ptr_q] = fetch_pc_q;
        wr_ptr_d          = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
      data_q      <= '{default: '0};
      pcbuf_q     <= '{default: '0};
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= CNT_ZERO;
`ifdef IFETCH_ALIGN_CHK_EN
      fault_q     <= 1'b0;
      halt_pend_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      data_q      <= data_d;
      pcbuf_q     <= pcbuf_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
`ifdef IFETCH_ALIGN_CHK_EN
      fault_q     <= fault_d;
      halt_pend_q <= halt_pend_d;
`endif
    end
  end

endmodule
